wb_regfile: RTL and testbench

- Writeback stage plus architectural register file; sits directly downstream of the MEM/WB pipeline register.
- Selects the writeback value (ALU result, load data, immediate or register move) from the MEM/WB fields and writes it to an 8-entry x 8-bit register file.
- Provides two read ports to decode, with same-cycle write bypass, and exports the writeback value for forwarding into EX.
- Tracks retired instructions and a sticky halt state.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/regfile_2r1w.sv | 44 ++++
 rtl/wb_regfile.sv | 86 ++++++++
 tb/tb_wb_regfile.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, datapath types and writeback FSM states
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef logic [2:0] reg_addr_t;
  typedef logic [7:0] data_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - register storage with two combinational read ports and write-first bypass
module regfile_2r1w #(
  parameter int DATA_W      = 8,
  parameter int NREGS       = 8,
  parameter int ZERO_REG_EN = 1,
  parameter int AW          = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_zero1;
  logic              w_zero2;
  logic              w_wzero;

  assign w_zero1 = (ZERO_REG_EN != 0) && (i_raddr1 == '0);
  assign w_zero2 = (ZERO_REG_EN != 0) && (i_raddr2 == '0);
  assign w_wzero = (ZERO_REG_EN != 0) && (i_waddr == '0);

  // The zero-register rule wins over the bypass so r0 always reads 0.
  assign o_rdata1 = w_zero1 ? '0 :
                    (i_we && (i_raddr1 == i_waddr)) ? i_wdata : r_regs[i_raddr1];
  assign o_rdata2 = w_zero2 ? '0 :
                    (i_we && (i_raddr2 == i_waddr)) ? i_wdata : r_regs[i_raddr2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && !w_wzero) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback source select, halt FSM, retire counter and register file
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NREGS       = 8,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16,
  parameter int AW          = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              writeReg_i,
  input  logic [AW-1:0]     regD_i,
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] alu_reg_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [2:0]        imm_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_en_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retired_o
);

  wb_state_t        r_state;
  logic [CNT_W-1:0] r_retired;
  logic             w_halted;
  logic             w_dst_zero;

  assign w_halted   = (r_state == ST_HALTED);
  assign w_dst_zero = (ZERO_REG_EN != 0) && (regD_i == '0);

  always_comb begin
    wb_data_o = alu_reg_i;
    case (opcode_i)
      OP_LOAD: wb_data_o = q_i;
      OP_LI:   wb_data_o = {{(DATA_W-3){1'b0}}, imm_i};
      OP_MOV:  wb_data_o = data1_i;
      default: wb_data_o = alu_reg_i;
    endcase
  end

  assign wb_en_o = valid_i && writeReg_i && !w_halted && !reset && !w_dst_zero;

  // Once halted, only reset brings the stage back; the HALT itself still retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_retired <= '0;
    end else if (r_state == ST_RUN && valid_i) begin
      if (r_retired != '1) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (opcode_i == OP_HALT) begin
        r_state <= ST_HALTED;
      end
    end
  end

  assign halted_o  = w_halted;
  assign retired_o = r_retired;

  regfile_2r1w #(
    .DATA_W      (DATA_W),
    .NREGS       (NREGS),
    .ZERO_REG_EN (ZERO_REG_EN),
    .AW          (AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (wb_en_o),
    .i_waddr  (regD_i),
    .i_wdata  (wb_data_o),
    .i_raddr1 (raddr1_i),
    .i_raddr2 (raddr2_i),
    .o_rdata1 (rdata1_o),
    .o_rdata2 (rdata2_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile against a reference model
module tb_wb_regfile;
  import cpu_pkg::*;

  logic       clk;
  logic       reset;
  logic       valid_i;
  logic       writeReg_i;
  logic [2:0] regD_i;
  logic [3:0] opcode_i;
  logic [7:0] alu_reg_i;
  logic [7:0] q_i;
  logic [7:0] data1_i;
  logic [2:0] imm_i;
  logic [2:0] raddr1_i;
  logic [2:0] raddr2_i;

  logic [7:0]  rdata1_o, rdata2_o, wb_data_o;
  logic        wb_en_o, halted_o;
  logic [15:0] retired_o;

  logic [7:0]  s_rdata1, s_rdata2, s_wb_data;
  logic        s_wb_en, s_halted;
  logic [1:0]  s_retired;

  logic [7:0] m_regs [8];
  int         m_ret;
  bit         m_halt;
  int         n_checks;
  int         n_errors;

  wb_regfile dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .writeReg_i(writeReg_i),
    .regD_i(regD_i), .opcode_i(opcode_i), .alu_reg_i(alu_reg_i), .q_i(q_i),
    .data1_i(data1_i), .imm_i(imm_i), .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
    .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .wb_data_o(wb_data_o),
    .wb_en_o(wb_en_o), .halted_o(halted_o), .retired_o(retired_o)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  wb_regfile #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .valid_i(valid_i), .writeReg_i(writeReg_i),
    .regD_i(regD_i), .opcode_i(opcode_i), .alu_reg_i(alu_reg_i), .q_i(q_i),
    .data1_i(data1_i), .imm_i(imm_i), .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
    .rdata1_o(s_rdata1), .rdata2_o(s_rdata2), .wb_data_o(s_wb_data),
    .wb_en_o(s_wb_en), .halted_o(s_halted), .retired_o(s_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_src(input logic [3:0] op, input logic [7:0] alu,
                                       input logic [7:0] q, input logic [7:0] d1,
                                       input logic [2:0] imm);
    if (op == OP_LOAD) return q;
    if (op == OP_LI)   return {5'd0, imm};
    if (op == OP_MOV)  return d1;
    return alu;
  endfunction

  // Called just after a rising edge: drives one slot, checks combinational outputs, clocks it.
  task automatic step(input bit rst, input bit v, input bit wr, input logic [2:0] rd,
                      input logic [3:0] op, input logic [7:0] alu, input logic [7:0] q,
                      input logic [7:0] d1, input logic [2:0] imm,
                      input logic [2:0] ra1, input logic [2:0] ra2);
    logic [7:0] e_wb, e_r1, e_r2;
    bit         e_en;
    reset = rst; valid_i = v; writeReg_i = wr; regD_i = rd; opcode_i = op;
    alu_reg_i = alu; q_i = q; data1_i = d1; imm_i = imm; raddr1_i = ra1; raddr2_i = ra2;
    e_wb = m_src(op, alu, q, d1, imm);
    e_en = v && wr && !m_halt && !rst && (rd != 3'd0);
    e_r1 = (ra1 == 3'd0) ? 8'h00 : (e_en && ra1 == rd) ? e_wb : m_regs[ra1];
    e_r2 = (ra2 == 3'd0) ? 8'h00 : (e_en && ra2 == rd) ? e_wb : m_regs[ra2];
    #3;
    chk("wb_data", wb_data_o, e_wb);
    chk("wb_en", wb_en_o, e_en);
    chk("rdata1", rdata1_o, e_r1);
    chk("rdata2", rdata2_o, e_r2);
    chk("sat_wb_en", s_wb_en, e_en);
    chk("sat_rdata1", s_rdata1, e_r1);
    chk("sat_rdata2", s_rdata2, e_r2);
    chk("sat_wb_data", s_wb_data, e_wb);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_ret  = 0;
      m_halt = 0;
    end else begin
      if (e_en) m_regs[rd] = e_wb;
      if (v && !m_halt) begin
        m_ret++;
        if (op == OP_HALT) m_halt = 1;
      end
    end
    chk("retired", retired_o, (m_ret > 16'hFFFF) ? 16'hFFFF : m_ret);
    chk("halted", halted_o, m_halt);
    chk("sat_retired", s_retired, (m_ret > 3) ? 3 : m_ret);
    chk("sat_halted", s_halted, m_halt);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 3'd0, OP_NOP, 8'h00, 8'h00, 8'h00, 3'd0, 3'(i), 3'(7 - i));
      chk(tag, rdata1_o, 8'h00);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_ret = 0; m_halt = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    reset = 1; valid_i = 0; writeReg_i = 0; regD_i = 0; opcode_i = 0;
    alu_reg_i = 0; q_i = 0; data1_i = 0; imm_i = 0; raddr1_i = 0; raddr2_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_retired", retired_o, 16'h0000);
    chk("reset_halted", halted_o, 1'b0);
    read_all_zero("reset_regs");

    step(0, 1, 1, 3'd3, 4'h1, 8'h5A, 8'h00, 8'h00, 3'd0, 3'd3, 3'd0);
    step(0, 0, 0, 3'd0, OP_NOP, 8'h00, 8'h00, 8'h00, 3'd0, 3'd3, 3'd3);
    chk("r3_after_alu", rdata1_o, 8'h5A);
    chk("retired_after_alu", retired_o, 16'd1);

    step(0, 1, 1, 3'd1, OP_LOAD, 8'hEE, 8'hC3, 8'hDD, 3'd7, 3'd1, 3'd0);
    step(0, 1, 1, 3'd2, OP_LI,   8'hEE, 8'hCC, 8'hDD, 3'd5, 3'd1, 3'd2);
    step(0, 1, 1, 3'd4, OP_MOV,  8'hEE, 8'hCC, 8'h77, 3'd5, 3'd2, 3'd4);
    step(0, 0, 0, 3'd0, OP_NOP, 8'h00, 8'h00, 8'h00, 3'd0, 3'd1, 3'd2);
    chk("r1_load", rdata1_o, 8'hC3);
    chk("r2_li", rdata2_o, 8'h05);
    step(0, 0, 0, 3'd0, OP_NOP, 8'h00, 8'h00, 8'h00, 3'd0, 3'd4, 3'd0);
    chk("r4_mov", rdata1_o, 8'h77);

    step(0, 1, 1, 3'd0, 4'h2, 8'hFF, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
    chk("r0_zero", rdata1_o, 8'h00);
    chk("r0_no_wb_en", wb_en_o, 1'b0);
    step(0, 0, 1, 3'd5, 4'h1, 8'h11, 8'h00, 8'h00, 3'd0, 3'd5, 3'd5);
    chk("bubble_r5", rdata1_o, 8'h00);
    chk("bubble_retired", retired_o, 16'd5);

    for (int n = 0; n < 300; n++) begin
      step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 14)), 8'($urandom), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    step(0, 1, 1, 3'd6, 4'h3, 8'h21, 8'h00, 8'h00, 3'd0, 3'd6, 3'd0);
    step(0, 1, 1, 3'd2, OP_HALT, 8'h3C, 8'h00, 8'h00, 3'd0, 3'd2, 3'd0);
    chk("halt_flag", halted_o, 1'b1);
    step(0, 1, 1, 3'd6, 4'h1, 8'h99, 8'h00, 8'h00, 3'd0, 3'd6, 3'd2);
    chk("halt_r6_kept", rdata1_o, 8'h21);
    chk("halt_r2_written", rdata2_o, 8'h3C);
    for (int n = 0; n < 20; n++) begin
      step(0, 1, 1, 3'($urandom_range(1, 7)), 4'($urandom_range(0, 15)), 8'($urandom),
           8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    step(1, 0, 0, 3'd0, OP_NOP, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
    chk("halt_cleared", halted_o, 1'b0);
    read_all_zero("post_halt_regs");

    for (int n = 0; n < 6; n++) begin
      step(0, 1, 1, 3'd7, 4'h4, 8'h5C, 8'h00, 8'h00, 3'd0, 3'd7, 3'd0);
    end
    chk("sat_hold", s_retired, 2'd3);
    step(1, 1, 1, 3'd7, 4'h1, 8'h42, 8'h00, 8'h00, 3'd0, 3'd7, 3'd7);
    step(0, 0, 0, 3'd0, OP_NOP, 8'h00, 8'h00, 8'h00, 3'd0, 3'd7, 3'd0);
    chk("reset_prio_r7", rdata1_o, 8'h00);
    chk("reset_prio_retired", retired_o, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
